// File: rtl/deinterleaver.sv
// -----------------------------------------------------------------------------
// deinterleaver
//
// Receive-side inverse of the block interleaver.  Input elements arrive in
// column-major order of a row x col matrix.  Each one is written to its
// row-major address in one of two ping-pong banks.  A completed bank is then
// streamed out in original (row-major) order, with m_axis_tlast on the last
// element of the block.  Both directions sustain one element per cycle.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   s_axis_tdata   interleaved input element (width bits)
//   s_axis_tvalid  input valid
//   s_axis_tlast   upstream end-of-block marker, used only for alignment check
//   s_axis_tready  input accept (registered, independent of s_axis_tvalid)
//   m_axis_tdata   deinterleaved output element (width bits)
//   m_axis_tvalid  output valid
//   m_axis_tlast   high on element N-1 of each block
//   m_axis_tready  downstream accept
//   err_align      one-cycle pulse when s_axis_tlast disagrees with the count
//
// Bank states
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   BANK_EMPTY     | free, may be claimed by the write side
//   BANK_FILLING   | write side has stored at least one beat of a block
//   BANK_FULL      | all N elements stored, waiting for the read side
//   BANK_DRAINING  | read side is issuing reads from this bank
// -----------------------------------------------------------------------------
module deinterleaver #(
  parameter int width = 1,
  parameter int row   = 512,
  parameter int col   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [width-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             err_align
);

  localparam int N  = row * col;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(row);
  localparam int CW = $clog2(col);

  localparam logic [RW-1:0] R_LAST   = RW'(row - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(col - 1);
  localparam logic [AW-1:0] RD_LAST  = AW'(N - 1);
  localparam logic [AW-1:0] COL_STEP = AW'(col);

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t bank_q [2];
  bank_state_t bank_d [2];

  // write side
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wsel_q, wsel_d;
  logic          ready_q, ready_d;
  logic          err_align_q, err_align_d;

  // read side
  logic [AW-1:0] rd_q, rd_d;
  logic          rsel_q, rsel_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;

  // output register and skid entry
  logic             out_valid_q, out_valid_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             skid_valid_q, skid_valid_d;
  logic [width-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;

  // storage: bank select is the address MSB
  logic [width-1:0] mem [2**(AW+1)];
  logic [width-1:0] rdata_q;

  logic       accept;
  logic       wr_last;
  logic       can_read;
  logic       rd_issue;
  logic       pop;
  logic [1:0] occ;

  assign accept  = s_axis_tvalid && ready_q;
  assign wr_last = (r_q == R_LAST) && (c_q == C_LAST);

  // ---------------------------------------------------------------------------
  // state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      r_q          <= '0;
      c_q          <= '0;
      waddr_q      <= '0;
      wsel_q       <= 1'b0;
      ready_q      <= 1'b0;
      err_align_q  <= 1'b0;
      rd_q         <= '0;
      rsel_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      r_q          <= r_d;
      c_q          <= c_d;
      waddr_q      <= waddr_d;
      wsel_q       <= wsel_d;
      ready_q      <= ready_d;
      err_align_q  <= err_align_d;
      rd_q         <= rd_d;
      rsel_q       <= rsel_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // Memory content is not reset; a bank is only ever read once it is FULL,
  // so stale data from before a reset can never reach the output.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wsel_q, waddr_q}] <= s_axis_tdata;
    end
    rdata_q <= mem[{rsel_q, rd_q}];
  end

  // ---------------------------------------------------------------------------
  // next state: bank states, write counters, read counter
  // ---------------------------------------------------------------------------
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    r_d         = r_q;
    c_d         = c_q;
    waddr_d     = waddr_q;
    wsel_d      = wsel_q;
    rd_d        = rd_q;
    rsel_d      = rsel_q;
    err_align_d = accept && (s_axis_tlast != wr_last);

    // waddr tracks r*col + c: +col along a column, c+1 at the top of the next
    if (accept) begin
      if (wr_last) begin
        r_d            = '0;
        c_d            = '0;
        waddr_d        = '0;
        wsel_d         = ~wsel_q;
        bank_d[wsel_q] = BANK_FULL;
      end else begin
        if (bank_q[wsel_q] == BANK_EMPTY) begin
          bank_d[wsel_q] = BANK_FILLING;
        end
        if (r_q == R_LAST) begin
          r_d     = '0;
          c_d     = c_q + 1'b1;
          waddr_d = AW'(c_q) + AW'(1);
        end else begin
          r_d     = r_q + 1'b1;
          waddr_d = waddr_q + COL_STEP;
        end
      end
    end

    // write and read never touch the same bank in one cycle: the write side
    // only owns EMPTY/FILLING banks, the read side only FULL/DRAINING ones
    if (rd_issue) begin
      if (rd_q == RD_LAST) begin
        rd_d           = '0;
        rsel_d         = ~rsel_q;
        bank_d[rsel_q] = BANK_EMPTY;
      end else begin
        rd_d           = rd_q + 1'b1;
        bank_d[rsel_q] = BANK_DRAINING;
      end
    end

    // registered ready looks at the post-edge bank state, so a bank freed by
    // the read side shows tready on the cycle after it empties
    ready_d = (bank_d[wsel_d] == BANK_EMPTY) || (bank_d[wsel_d] == BANK_FILLING);
  end

  // ---------------------------------------------------------------------------
  // output: read issue and output register / skid entry
  // ---------------------------------------------------------------------------
  always_comb begin
    pop      = out_valid_q && m_axis_tready;
    can_read = (bank_q[rsel_q] == BANK_FULL) || (bank_q[rsel_q] == BANK_DRAINING);

    // Occupancy after this edge, counting the read already in flight.  A new
    // read is issued only if its data is sure to find a free slot next cycle.
    occ      = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rvalid_q) - 2'(pop);
    rd_issue = can_read && (occ <= 2'd1);

    rvalid_d = rd_issue;
    rlast_d  = rd_issue && (rd_q == RD_LAST);

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = rvalid_q;
        if (rvalid_q) begin
          skid_data_d = rdata_q;
          skid_last_d = rlast_q;
        end
      end else begin
        out_valid_d = rvalid_q;
        if (rvalid_q) begin
          out_data_d = rdata_q;
          out_last_d = rlast_q;
        end
      end
    end else if (!out_valid_q) begin
      out_valid_d = rvalid_q;
      if (rvalid_q) begin
        out_data_d = rdata_q;
        out_last_d = rlast_q;
      end
    end else if (rvalid_q) begin
      // output stalled: park the returning read in the skid entry
      skid_valid_d = 1'b1;
      skid_data_d  = rdata_q;
      skid_last_d  = rlast_q;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign err_align     = err_align_q;

endmodule

// File: tb/tb_deinterleaver.sv
module tb_deinterleaver;

  localparam int RA = 4;
  localparam int CA = 3;
  localparam int NA = RA * CA;
  localparam int RB = 512;
  localparam int CB = 32;
  localparam int NB = RB * CB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // small instance (4 x 3, 8-bit)
  logic [7:0] s_data_a;
  logic       s_valid_a, s_last_a, s_ready_a;
  logic [7:0] m_data_a;
  logic       m_valid_a, m_last_a, m_ready_a, err_a;

  // default instance (512 x 32, 1-bit)
  logic s_data_b, s_valid_b, s_last_b, s_ready_b;
  logic m_data_b, m_valid_b, m_last_b, m_ready_b, err_b;

  deinterleaver #(.width(8), .row(RA), .col(CA)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data_a), .s_axis_tvalid(s_valid_a), .s_axis_tlast(s_last_a),
    .s_axis_tready(s_ready_a),
    .m_axis_tdata(m_data_a), .m_axis_tvalid(m_valid_a), .m_axis_tlast(m_last_a),
    .m_axis_tready(m_ready_a), .err_align(err_a)
  );

  deinterleaver dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data_b), .s_axis_tvalid(s_valid_b), .s_axis_tlast(s_last_b),
    .s_axis_tready(s_ready_b),
    .m_axis_tdata(m_data_b), .m_axis_tvalid(m_valid_b), .m_axis_tlast(m_last_b),
    .m_axis_tready(m_ready_b), .err_align(err_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [7:0] in_data;
    logic       in_last;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // m_axis_tready driver for instance a: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready_a = 1'b1;
      1:       m_ready_a = ($urandom_range(0, 1) == 1);
      default: m_ready_a = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // monitor for instance a: alignment model, hold checks, output capture
  // ---------------------------------------------------------------------------
  beat_t      cap_a[$];
  beat_t      exp_a[$];
  int         beat_k;
  bit         exp_err_pend;
  bit         prev_stall;
  bit         prev_valid;
  logic [7:0] prev_data;
  logic       prev_last;
  int         first_valid_cyc = -1;
  int         err_cnt_a = 0;
  int         gap_cnt = 0;
  int         gap_target = 0;

  always @(negedge clk) begin
    if (rst) begin
      beat_k       = 0;
      exp_err_pend = 1'b0;
      prev_stall   = 1'b0;
      prev_valid   = 1'b0;
    end else begin
      check("err_align_a", 32'(err_a), 32'(exp_err_pend));
      if (err_a) err_cnt_a++;
      exp_err_pend = s_valid_a && s_ready_a && (s_last_a != (beat_k == NA - 1));
      if (s_valid_a && s_ready_a) beat_k = (beat_k == NA - 1) ? 0 : beat_k + 1;

      if (prev_stall) begin
        check("hold_valid", 32'(m_valid_a), 32'd1);
        check("hold_data", 32'(m_data_a), 32'(prev_data));
        check("hold_last", 32'(m_last_a), 32'(prev_last));
      end
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
      prev_last  = m_last_a;

      if (m_valid_a && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      prev_valid = m_valid_a;

      if (gap_target > 0 && cap_a.size() > 0 && cap_a.size() < gap_target && !m_valid_a)
        gap_cnt++;

      if (m_valid_a && m_ready_a) begin
        beat_t b;
        b.d = m_data_a;
        b.l = m_last_a;
        cap_a.push_back(b);
      end
    end
  end

  // monitor for instance b
  logic capb_d[$];
  logic capb_l[$];
  int   err_cnt_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid_b && m_ready_b) begin
        capb_d.push_back(m_data_b);
        capb_l.push_back(m_last_b);
      end
      if (err_b) err_cnt_b++;
    end
  end

  // ---------------------------------------------------------------------------
  // drivers (called at posedge+1; return at posedge+1 after acceptance)
  // ---------------------------------------------------------------------------
  task automatic send_a(input logic [7:0] d, input logic l);
    int guard = 0;
    s_data_a  = d;
    s_last_a  = l;
    s_valid_a = 1'b1;
    @(negedge clk);
    while (!s_ready_a && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!s_ready_a) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_a_timeout: tready stuck at 0, required 1 (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    s_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic d, input logic l);
    int guard = 0;
    s_data_b  = d;
    s_last_b  = l;
    s_valid_b = 1'b1;
    @(negedge clk);
    while (!s_ready_b && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!s_ready_b) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_b_timeout: tready stuck at 0, required 1 (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1;
    s_valid_b = 1'b0;
  endtask

  // Interleave an original-order block into column-major beats and queue the
  // original order as the expected output.
  task automatic send_block_a(input logic [7:0] blk [NA], input int extra_last,
                              input bit final_last, input bit idles);
    for (int j = 0; j < NA; j++) begin
      beat_t e;
      e.d = blk[j];
      e.l = (j == NA - 1);
      exp_a.push_back(e);
    end
    for (int k = 0; k < NA; k++) begin
      if (idles && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_a(blk[(k % RA) * CA + k / RA], (k == NA - 1) ? final_last : (k == extra_last));
    end
  endtask

  task automatic drain_check_a(input string name);
    int guard = 0;
    while (cap_a.size() < exp_a.size() && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check({name, "_count"}, 32'(cap_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size(); i++) begin
      if (i < cap_a.size()) begin
        check({name, "_data"}, 32'(cap_a[i].d), 32'(exp_a[i].d));
        check({name, "_last"}, 32'(cap_a[i].l), 32'(exp_a[i].l));
      end
    end
    exp_a.delete();
    cap_a.delete();
  endtask

  // ---------------------------------------------------------------------------
  // test sequence
  // ---------------------------------------------------------------------------
  vec_t       tbl [NA];
  logic [7:0] patt [NA];
  logic [7:0] rblk [NA];
  logic [7:0] old_blk [NA];
  logic       blk_b [NB];

  initial begin
    int t_last;
    int c0;
    int e0;
    int g;

    s_valid_a = 1'b0; s_data_a = '0; s_last_a = 1'b0;
    s_valid_b = 1'b0; s_data_b = 1'b0; s_last_b = 1'b0;
    m_ready_b = 1'b1;
    rst = 1'b1;

    for (int j = 0; j < NA; j++) begin
      patt[j]    = 8'(j);
      old_blk[j] = 8'(8'h40 + j);
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready_a", 32'(s_ready_a), 32'd0);
    check("rst_m_valid_a", 32'(m_valid_a), 32'd0);
    check("rst_m_last_a", 32'(m_last_a), 32'd0);
    check("rst_m_data_a", 32'(m_data_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_s_ready_b", 32'(s_ready_b), 32'd0);
    check("rst_m_valid_b", 32'(m_valid_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(s_ready_a), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge_a", 32'(s_ready_a), 32'd1);
    check("ready_after_edge_b", 32'(s_ready_b), 32'd1);

    // basic deinterleave, table driven
    tbl[0]  = '{8'd0,  1'b0, 8'd0,  1'b0};
    tbl[1]  = '{8'd3,  1'b0, 8'd1,  1'b0};
    tbl[2]  = '{8'd6,  1'b0, 8'd2,  1'b0};
    tbl[3]  = '{8'd9,  1'b0, 8'd3,  1'b0};
    tbl[4]  = '{8'd1,  1'b0, 8'd4,  1'b0};
    tbl[5]  = '{8'd4,  1'b0, 8'd5,  1'b0};
    tbl[6]  = '{8'd7,  1'b0, 8'd6,  1'b0};
    tbl[7]  = '{8'd10, 1'b0, 8'd7,  1'b0};
    tbl[8]  = '{8'd2,  1'b0, 8'd8,  1'b0};
    tbl[9]  = '{8'd5,  1'b0, 8'd9,  1'b0};
    tbl[10] = '{8'd8,  1'b0, 8'd10, 1'b0};
    tbl[11] = '{8'd11, 1'b1, 8'd11, 1'b1};

    first_valid_cyc = -1;
    err_cnt_a = 0;
    for (int i = 0; i < NA; i++) send_a(tbl[i].in_data, tbl[i].in_last);
    t_last = cyc;
    g = 0;
    while (cap_a.size() < NA && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("basic_count", 32'(cap_a.size()), 32'(NA));
    for (int i = 0; i < NA; i++) begin
      if (i < cap_a.size()) begin
        check("basic_data", 32'(cap_a[i].d), 32'(tbl[i].exp_data));
        check("basic_last", 32'(cap_a[i].l), 32'(tbl[i].exp_last));
      end
    end
    check("basic_latency", 32'(first_valid_cyc), 32'(t_last + 2));
    check("basic_no_err", 32'(err_cnt_a), 32'd0);
    cap_a.delete();

    // ping-pong streaming, three blocks back to back
    gap_cnt = 0;
    gap_target = 3 * NA;
    c0 = cyc;
    send_block_a(patt, -1, 1'b1, 1'b0);
    send_block_a(patt, -1, 1'b1, 1'b0);
    check("pingpong_in_b2b", 32'(cyc - c0), 32'(2 * NA));
    send_block_a(patt, -1, 1'b1, 1'b0);
    drain_check_a("pingpong");
    check("pingpong_gaps", 32'(gap_cnt), 32'd0);
    gap_target = 0;

    // backpressure with random data and random input idles
    rdy_mode = 1;
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < NA; j++) rblk[j] = 8'($urandom);
      send_block_a(rblk, -1, 1'b1, 1'b1);
    end
    drain_check_a("backpressure");
    rdy_mode = 0;

    // alignment: early tlast on beat 7, then a missing final tlast
    e0 = err_cnt_a;
    send_block_a(patt, 7, 1'b1, 1'b0);
    drain_check_a("align_early");
    check("align_early_pulses", 32'(err_cnt_a - e0), 32'd1);
    e0 = err_cnt_a;
    send_block_a(patt, -1, 1'b0, 1'b0);
    drain_check_a("align_missing");
    check("align_missing_pulses", 32'(err_cnt_a - e0), 32'd1);

    // reset mid-operation with a stalled block and a partial block buffered
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_block_a(old_blk, -1, 1'b1, 1'b0);
    g = 0;
    while (!m_valid_a && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(m_valid_a), 32'd1);
    check("pre_rst_data", 32'(m_data_a), 32'h40);
    for (int k = 0; k < 5; k++) send_a(patt[(k % RA) * CA + k / RA], 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_s_ready", 32'(s_ready_a), 32'd0);
    check("midrst_m_valid", 32'(m_valid_a), 32'd0);
    check("midrst_m_last", 32'(m_last_a), 32'd0);
    check("midrst_m_data", 32'(m_data_a), 32'd0);
    check("midrst_err", 32'(err_a), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    exp_a.delete();
    cap_a.delete();
    #1;
    check("midrst_ready_before_edge", 32'(s_ready_a), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_ready_after_edge", 32'(s_ready_a), 32'd1);
    send_block_a(patt, -1, 1'b1, 1'b0);
    drain_check_a("fresh");
    repeat (20) @(posedge clk);
    #1;
    check("no_remnant_count", 32'(cap_a.size()), 32'd0);
    check("no_remnant_valid", 32'(m_valid_a), 32'd0);

    // default geometry: one random bit block through the interleave model
    for (int j = 0; j < NB; j++) blk_b[j] = 1'($urandom_range(0, 1));
    for (int k = 0; k < NB; k++) send_b(blk_b[(k % RB) * CB + k / RB], (k == NB - 1));
    g = 0;
    while (capb_d.size() < NB && g < 40000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("default_count", 32'(capb_d.size()), 32'(NB));
    for (int i = 0; i < NB; i++) begin
      if (i < capb_d.size()) begin
        check("default_data", 32'(capb_d[i]), 32'(blk_b[i]));
        check("default_last", 32'(capb_l[i]), 32'(i == NB - 1));
      end
    end
    check("default_no_err", 32'(err_cnt_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
